// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
//   - mdu_op_e    : operation encoding as presented on i_op
//   - mdu_state_e : control FSM states
//   - MDU_DATA_W  : default operand width
package mdu_pkg;

  localparam int unsigned MDU_DATA_W = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // Divide ops share the restoring-subtract datapath mode.
  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Signed ops need operand magnitudes and a result sign fixup.
  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: one radix-2 step per cycle over a 2*DATA_W accumulator.
//   Multiply: acc = {partial product, multiplier}; add-and-shift-right.
//   Divide  : acc = {remainder, dividend/quotient}; shift-left-and-restoring-subtract.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_load            load magnitudes i_a/i_b and mode i_is_div
//   i_step            perform one iteration
//   i_is_div          1 = divide mode, 0 = multiply mode (sampled on i_load)
//   i_a, i_b          operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   o_acc             accumulator: product, or {remainder, quotient}
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = MDU_DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_is_div,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  output logic [2*DATA_W-1:0]   o_acc
);

  localparam int unsigned ACC_W = 2 * DATA_W;

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_step;
  logic [DATA_W-1:0] opnd_q;
  logic              is_div_q;
  logic [DATA_W:0]   add_a;
  logic [DATA_W:0]   add_b;
  logic [DATA_W+1:0] sum;
  logic              ge;

  // Shared adder/subtractor; in divide mode the top bit of sum is "no borrow".
  always_comb begin
    add_a = is_div_q ? acc_q[ACC_W-1:DATA_W-1] : {1'b0, acc_q[ACC_W-1:DATA_W]};
    add_b = is_div_q ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
    sum   = {1'b0, add_a} + {1'b0, add_b} + (DATA_W+2)'(is_div_q);
  end

  // Next accumulator value for one iteration.
  always_comb begin
    ge       = sum[DATA_W+1];
    acc_step = acc_q;
    if (is_div_q) begin
      // Shifted remainder is restored (kept) when it is below the divisor.
      acc_step = {(ge ? sum[DATA_W-1:0] : acc_q[ACC_W-2:DATA_W-1]),
                  acc_q[DATA_W-2:0], ge};
    end else if (acc_q[0]) begin
      acc_step = {sum[DATA_W:0], acc_q[DATA_W-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[ACC_W-1:1]};
    end
  end

  // Accumulator, stationary operand and mode registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
    end else if (i_load) begin
      acc_q    <= {{DATA_W{1'b0}}, (i_is_div ? i_a : i_b)};
      opnd_q   <= i_is_div ? i_b : i_a;
      is_div_q <= i_is_div;
    end else if (i_step) begin
      acc_q    <= acc_step;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
// Latency is DATA_W+2 edges from the accepting edge to HI/LO update.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start, i_op     launch op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU) when idle
//   i_rs, i_rt        operands A and B, sampled only at launch
//   i_mthi, i_mtlo    write i_rs into HI / LO while idle (dropped if i_start)
//   o_hi, o_lo        HI / LO registers
//   o_busy            operation in progress
//   o_done            one-cycle pulse after HI/LO take a result
//   o_div0            (only with MDU_DIV0_FLAG_EN) sticky divide-by-zero flag,
//                     cleared by the next accepted i_start
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = MDU_DATA_W,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  input  logic              i_mthi,
  input  logic              i_mtlo,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_busy,
  output logic              o_done
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic              o_div0
`endif
);

  localparam int unsigned ACC_W = 2 * DATA_W;

  mdu_op_e           op;
  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, busy_d;
  logic              done_q;
  logic              dp_load, dp_step, fix_en;
  logic              is_div_q, res_neg_q, rem_neg_q, b_zero_q;
  logic              is_signed;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [ACC_W-1:0]  dp_acc;
  logic [ACC_W-1:0]  prod_fix;
  logic [DATA_W-1:0] quo, rem, quo_fix, rem_fix;
  logic [DATA_W-1:0] fix_hi, fix_lo;
  logic [DATA_W-1:0] hi_q, lo_q;

  assign op        = mdu_op_e'(i_op);
  assign is_signed = op_is_signed(op);

  // Operand magnitudes; 0x80..0 maps to itself, which is the correct unsigned magnitude.
  assign a_mag = (is_signed && i_rs[DATA_W-1]) ? (DATA_W'(0) - i_rs) : i_rs;
  assign b_mag = (is_signed && i_rt[DATA_W-1]) ? (DATA_W'(0) - i_rt) : i_rt;

  // FSM state register plus registered busy/done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= fix_en;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_CALC;
      ST_CALC: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    dp_load = 1'b0;
    dp_step = 1'b0;
    fix_en  = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: dp_load = i_start;
      ST_CALC: dp_step = 1'b1;
      ST_FIX:  fix_en  = 1'b1;
      default: ;
    endcase
  end

  // Iteration counter and per-operation sign/mode bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
    end else if (dp_load) begin
      cnt_q     <= '0;
      is_div_q  <= op_is_div(op);
      res_neg_q <= is_signed & (i_rs[DATA_W-1] ^ i_rt[DATA_W-1]);
      rem_neg_q <= is_signed & i_rs[DATA_W-1];
      b_zero_q  <= (i_rt == '0);
    end else if (dp_step) begin
      cnt_q     <= cnt_q + CNT_W'(1);
    end
  end

  mdu_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (dp_load),
    .i_step   (dp_step),
    .i_is_div (op_is_div(op)),
    .i_a      (a_mag),
    .i_b      (b_mag),
    .o_acc    (dp_acc)
  );

  // Sign fixup. For divide-by-zero the remainder is |A| and restoring its sign
  // gives back A exactly; the quotient stays all ones.
  always_comb begin
    prod_fix = res_neg_q ? (ACC_W'(0) - dp_acc) : dp_acc;
    quo      = dp_acc[DATA_W-1:0];
    rem      = dp_acc[ACC_W-1:DATA_W];
    quo_fix  = (res_neg_q && !b_zero_q) ? (DATA_W'(0) - quo) : quo;
    rem_fix  = rem_neg_q ? (DATA_W'(0) - rem) : rem;
    fix_hi   = is_div_q ? rem_fix : prod_fix[ACC_W-1:DATA_W];
    fix_lo   = is_div_q ? quo_fix : prod_fix[DATA_W-1:0];
  end

  // HI/LO: result on the FIX edge, MT writes only when idle and not starting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fix_en) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end else if ((state_q == ST_IDLE) && !i_start) begin
      if (i_mthi) hi_q <= i_rs;
      if (i_mtlo) lo_q <= i_rs;
    end
  end

`ifdef MDU_DIV0_FLAG_EN
  logic div0_q;

  // Sticky divide-by-zero flag, cleared when the next op is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div0_q <= 1'b0;
    end else if (dp_load) begin
      div0_q <= 1'b0;
    end else if (fix_en && is_div_q && b_zero_q) begin
      div0_q <= 1'b1;
    end
  end

  assign o_div0 = div0_q;
`endif

  assign o_hi   = hi_q;
  assign o_lo   = lo_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
